sm_alu_seq: RTL and testbench
=============================

SM_ALU_SEQ -- requirements
Module: sm_alu_seq

Interface
REQ-001 Parameter WIDTH, default 3: magnitude bits per operand, range 2..8.
REQ-002 Parameter DIGITS, default 2: BCD digits displayed; SHALL satisfy 10^DIGITS > (2^WIDTH-1)^2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 ar  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 add, 01 subtract (a-b), 10 multiply, 11 reserved.
REQ-007 a_neg, b_neg  input  1 each  operand sign, 1 = negative.
REQ-008 a_mag, b_mag  input  WIDTH each  operand magnitudes.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when result registers update.
REQ-011 err  output  1  registered; 1 when last completed op was reserved.
REQ-012 res_neg  output  1  registered result sign.
REQ-013 res_mag  output  2*WIDTH  registered result magnitude.
REQ-014 seg_out  output  7*DIGITS  active-low segments; bits [6:0] = ones digit, bit0 = seg a ... bit6 = seg g.

Function
REQ-015 FSM states: IDLE, EXEC, CONV, DONE; transitions IDLE->EXEC on start, EXEC->CONV when arithmetic complete, CONV->DONE after 2*WIDTH cycles, DONE->IDLE unconditionally.
REQ-016 On start in IDLE, op and all operand inputs SHALL be latched; later input changes have no effect on that operation.
REQ-017 start while busy SHALL be ignored and not queued.
REQ-018 Add/subtract: sign-magnitude; subtract = add with b sign inverted; equal signs add magnitudes, unequal signs subtract smaller from larger with the larger's sign; EXEC lasts 1 cycle.
REQ-019 Multiply: shift-add, one multiplier bit per cycle, EXEC lasts WIDTH cycles; sign = a_neg XOR b_neg.
REQ-020 Zero magnitude result SHALL force sign positive (no negative zero).
REQ-021 op=11: result +0, err=1; timing identical to add.
REQ-022 CONV: shift-add-3 binary-to-BCD, one result bit per cycle, 2*WIDTH cycles.
REQ-023 Latency (start sampled at cycle t): add/sub/reserved done at t+2+2*WIDTH; multiply done at t+1+3*WIDTH.
REQ-024 res_neg, res_mag, err, seg_out SHALL update only in the DONE cycle and hold until the next DONE.
REQ-025 start may be high in the DONE cycle; it is ignored and is accepted only once the FSM is back in IDLE.

Reset
REQ-026 ar high at any edge, including mid-EXEC or mid-CONV, SHALL abort the operation and force IDLE.
REQ-027 Reset values: busy=0, done=0, err=0, res_neg=0, res_mag=0, and seg_out displaying "0" on every digit.

Configuration
REQ-028 Macro SM_ALU_MUL_EN: when defined, op=10 multiplies per REQ-019.
REQ-029 When SM_ALU_MUL_EN is undefined, op=10 behaves as reserved per REQ-021 and no multiplier datapath is synthesised.

Structure
REQ-030 Package sm_alu_pkg SHALL hold the op encodings, FSM state encoding and the active-low digit segment constants 0-9.
REQ-031 Sub-module seg7_digit SHALL decode one 4-bit BCD digit to 7 active-low segments; instantiated DIGITS times.

Verification (WIDTH=3, DIGITS=2, SM_ALU_MUL_EN defined)
REQ-032 add +5,-2 -> done at t+8; res_neg=0, res_mag=3, seg_out[6:0]=7'b0110000, seg_out[13:7]=digit 0.
REQ-033 sub -3,+4 -> done at t+8; res_neg=1, res_mag=7, err=0.
REQ-034 mul +7,-7 -> done at t+10; res_neg=1, res_mag=49, ones digit 7'b0010000, tens digit pattern 4.
REQ-035 sub +3,+3 and mul -0,+5 -> res_neg=0, res_mag=0.
REQ-036 start pulsed at t+3 during a busy add -> ignored, single done at t+8; ar high at t+5 -> busy=0 next cycle, all outputs at reset values, no done.
REQ-037 op=11 -> done at t+8, err=1, res_mag=0; rebuild without SM_ALU_MUL_EN, op=10 -> err=1, done at t+8.

Source files
------------

// File: rtl/sm_alu_pkg.sv
// rtl/sm_alu_pkg.sv - op codes, FSM state codes and active-low 7-segment digit patterns for sm_alu_seq
package sm_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_CONV = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // bit0 = segment a ... bit6 = segment g, 0 = lit
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sm_alu_seq_if.sv
// rtl/sm_alu_seq_if.sv - request/result bundle between a requester (master) and sm_alu_seq (slave)
interface sm_alu_seq_if #(
    parameter int WIDTH  = 3,
    parameter int DIGITS = 2
);
    logic                  start;
    logic [1:0]            op;
    logic                  a_neg;
    logic                  b_neg;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  res_neg;
    logic [2*WIDTH-1:0]    res_mag;
    logic [7*DIGITS-1:0]   seg_out;

    modport master (
        output start, op, a_neg, b_neg, a_mag, b_mag,
        input  busy, done, err, res_neg, res_mag, seg_out
    );

    modport slave (
        input  start, op, a_neg, b_neg, a_mag, b_mag,
        output busy, done, err, res_neg, res_mag, seg_out
    );
endinterface

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - one BCD digit to seven active-low segments
module seg7_digit
    import sm_alu_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = seg_of(bcd);
endmodule

// File: rtl/sm_alu_seq.sv
// rtl/sm_alu_seq.sv - sequential sign-magnitude add/sub/mul with BCD 7-segment readout; SM_ALU_MUL_EN enables multiply
module sm_alu_seq
    import sm_alu_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int DIGITS = 2
) (
    input  logic        clk,
    input  logic        ar,
    sm_alu_seq_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(RW + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(RW - 1);
    localparam logic [CW-1:0] MUL_LAST  = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;

    // mag_w keeps the result while bin_q is consumed by the BCD shifter
    logic [RW-1:0]    mag_w;
    logic [RW-1:0]    bin_q;
    logic             sign_w;
    logic             err_w;
    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_next;

    logic             err_q;
    logic             res_neg_q;
    logic [RW-1:0]    res_mag_q;
    logic [BW-1:0]    disp_q;
    logic [7*DIGITS-1:0] seg_w;

    logic             is_mul;
    logic             is_rsv;
    logic [RW-1:0]    mul_mag;
    logic             mul_neg;

    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic             b_sign;
    logic             as_neg;
    logic [RW-1:0]    as_mag;

    always_comb begin
        a_ext  = {{WIDTH{1'b0}}, a_q};
        b_ext  = {{WIDTH{1'b0}}, b_q};
        b_sign = b_neg_q ^ (op_q == OP_SUB);
        if (a_neg_q == b_sign) begin
            as_mag = a_ext + b_ext;
            as_neg = a_neg_q;
        end else if (a_q >= b_q) begin
            as_mag = a_ext - b_ext;
            as_neg = a_neg_q;
        end else begin
            as_mag = b_ext - a_ext;
            as_neg = b_sign;
        end
        if (as_mag == '0) begin
            as_neg = 1'b0;
        end
    end

    assign mul_neg = a_neg_q ^ b_neg_q;

`ifdef SM_ALU_MUL_EN
    logic [RW-1:0]    acc_q;
    logic [RW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;

    assign is_mul  = (op_q == OP_MUL);
    assign is_rsv  = (op_q == OP_RSV);
    assign mul_mag = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Operands are reloaded every idle cycle; the load on the start edge is the one that sticks
    always_ff @(posedge clk) begin
        if (ar) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (state == ST_IDLE) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus.a_mag};
            mplier_q <= bus.b_mag;
        end else if (state == ST_EXEC) begin
            acc_q    <= mul_mag;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign is_mul  = 1'b0;
    assign is_rsv  = op_q[1];
    assign mul_mag = '0;
`endif

    // Double-dabble step: add 3 to any digit >= 5, then shift in the next result bit
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BW-2:0], bin_q[RW-1]};
    end

    always_ff @(posedge clk) begin
        if (ar) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            mag_w     <= '0;
            bin_q     <= '0;
            sign_w    <= 1'b0;
            err_w     <= 1'b0;
            bcd_q     <= '0;
            err_q     <= 1'b0;
            res_neg_q <= 1'b0;
            res_mag_q <= '0;
            disp_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_neg_q <= bus.a_neg;
                        b_neg_q <= bus.b_neg;
                        a_q     <= bus.a_mag;
                        b_q     <= bus.b_mag;
                        cnt     <= '0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_mul) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == MUL_LAST) begin
                            mag_w  <= mul_mag;
                            bin_q  <= mul_mag;
                            sign_w <= mul_neg && (mul_mag != '0);
                            err_w  <= 1'b0;
                            bcd_q  <= '0;
                            cnt    <= '0;
                            state  <= ST_CONV;
                        end
                    end else begin
                        mag_w  <= is_rsv ? '0 : as_mag;
                        bin_q  <= is_rsv ? '0 : as_mag;
                        sign_w <= !is_rsv && as_neg;
                        err_w  <= is_rsv;
                        bcd_q  <= '0;
                        cnt    <= '0;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_q <= bcd_next;
                    bin_q <= bin_q << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CONV_LAST) begin
                        err_q     <= err_w;
                        res_neg_q <= sign_w;
                        res_mag_q <= mag_w;
                        disp_q    <= bcd_next;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit u_digit (
            .bcd (disp_q[4*g +: 4]),
            .seg (seg_w[7*g +: 7])
        );
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.err     = err_q;
    assign bus.res_neg = res_neg_q;
    assign bus.res_mag = res_mag_q;
    assign bus.seg_out = seg_w;

endmodule

// File: tb/tb_sm_alu_seq.sv
// tb/tb_sm_alu_seq.sv - directed checks of sm_alu_seq against a latency/arithmetic model
module tb_sm_alu_seq;
    localparam int W = 3;
    localparam int D = 2;
`ifdef SM_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam logic [13:0] Z2 = 14'b1000000_1000000;

    logic clk = 1'b0;
    logic ar  = 1'b1;
    always #5 clk = ~clk;

    sm_alu_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
    sm_alu_seq #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .ar(ar), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bit          pend = 1'b0;
    int          pend_done;
    logic        p_err, p_neg;
    int          p_mag;
    logic [13:0] p_seg;
    logic        h_err, h_neg;
    int          h_mag;
    logic [13:0] h_seg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] seg_model(input int mag);
        logic [13:0] s;
        int v;
        v = mag;
        for (int d = 0; d < D; d++) begin
            s[7*d +: 7] = seg_tab[v % 10];
            v = v / 10;
        end
        return s;
    endfunction

    // Reference: signed integer arithmetic plus the documented latencies
    always @(posedge clk) begin : model
        int old, av, bv, r, lat;
        old = cyc;
        if (ar) begin
            pend  = 1'b0;
            h_err = 1'b0;
            h_neg = 1'b0;
            h_mag = 0;
            h_seg = seg_model(0);
        end else if (pend && old == pend_done) begin
            pend = 1'b0;
        end else if (!pend && bus.start) begin
            av = bus.a_neg ? -int'(bus.a_mag) : int'(bus.a_mag);
            bv = bus.b_neg ? -int'(bus.b_mag) : int'(bus.b_mag);
            case (bus.op)
                2'b00:   r = av + bv;
                2'b01:   r = av - bv;
                2'b10:   r = MUL_EN ? av * bv : 0;
                default: r = 0;
            endcase
            p_err = (bus.op == 2'b11) || (bus.op == 2'b10 && !MUL_EN);
            lat   = (bus.op == 2'b10 && MUL_EN) ? 1 + 3 * W : 2 + 2 * W;
            p_neg = (r < 0);
            p_mag = (r < 0) ? -r : r;
            p_seg = seg_model(p_mag);
            pend_done = old + lat;
            pend  = 1'b1;
        end
        cyc = old + 1;
        if (pend && cyc == pend_done) begin
            h_err = p_err;
            h_neg = p_neg;
            h_mag = p_mag;
            h_seg = p_seg;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    bus.busy,    pend);
            chk("done",    bus.done,    pend && cyc == pend_done);
            chk("err",     bus.err,     h_err);
            chk("res_neg", bus.res_neg, h_neg);
            chk("res_mag", bus.res_mag, h_mag);
            chk("seg_out", bus.seg_out, h_seg);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input logic an, input logic [2:0] am,
                          input logic bn, input logic [2:0] bm, output int t);
        bus.op = op; bus.a_neg = an; bus.a_mag = am; bus.b_neg = bn; bus.b_mag = bm;
        bus.start = 1'b1;
        t = cyc;
        step();
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a_neg = 1'($urandom);
        bus.b_neg = 1'($urandom);
        bus.a_mag = 3'($urandom);
        bus.b_mag = 3'($urandom);
    endtask

    task automatic wait_done(input string nm, input int t, input int lat);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (bus.done === 1'b1);
        end
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_latency"}, cyc - t, lat);
    endtask

    task automatic run(input string nm, input logic [1:0] op, input logic an, input logic [2:0] am,
                       input logic bn, input logic [2:0] bm, input int lat, input logic en,
                       input int em, input logic ee, input logic [13:0] es);
        int t;
        launch(op, an, am, bn, bm, t);
        wait_done(nm, t, lat);
        chk({nm, "_neg"}, bus.res_neg, en);
        chk({nm, "_mag"}, bus.res_mag, em);
        chk({nm, "_err"}, bus.err, ee);
        chk({nm, "_seg"}, bus.seg_out, es);
        step();
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done === 1'b1) c++;
        end
        step();
    endtask

    initial begin : stim
        int t, c;
        bus.start = 1'b0; bus.op = 2'b00;
        bus.a_neg = 1'b0; bus.b_neg = 1'b0; bus.a_mag = '0; bus.b_mag = '0;
        repeat (3) @(posedge clk);
        #1;
        ar = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err",  bus.err, 0);
        chk("rst_neg",  bus.res_neg, 0);
        chk("rst_mag",  bus.res_mag, 0);
        chk("rst_seg",  bus.seg_out, Z2);
        step();

        run("add_p5_m2", 2'b00, 0, 3'd5, 1, 3'd2, 8, 0, 3,  0, 14'b1000000_0110000);
        run("sub_m3_p4", 2'b01, 1, 3'd3, 0, 3'd4, 8, 1, 7,  0, 14'b1000000_1111000);
        run("mul_p7_m7", 2'b10, 0, 3'd7, 1, 3'd7, MUL_EN ? 10 : 8, MUL_EN, MUL_EN ? 49 : 0,
            !MUL_EN, MUL_EN ? 14'b0011001_0010000 : Z2);
        run("sub_p3_p3", 2'b01, 0, 3'd3, 0, 3'd3, 8, 0, 0,  0, Z2);
        run("mul_m0_p5", 2'b10, 1, 3'd0, 0, 3'd5, MUL_EN ? 10 : 8, 0, 0, !MUL_EN, Z2);
        run("rsv_p6_p1", 2'b11, 0, 3'd6, 0, 3'd1, 8, 0, 0,  1, Z2);
        run("add_m7_m7", 2'b00, 1, 3'd7, 1, 3'd7, 8, 1, 14, 0, 14'b1111001_0011001);
        run("sub_p2_p6", 2'b01, 0, 3'd2, 0, 3'd6, 8, 1, 4,  0, 14'b1000000_0011001);
        run("add_p7_m7", 2'b00, 0, 3'd7, 1, 3'd7, 8, 0, 0,  0, Z2);
        run("mul_m6_m5", 2'b10, 1, 3'd6, 1, 3'd5, MUL_EN ? 10 : 8, 0, MUL_EN ? 30 : 0,
            !MUL_EN, MUL_EN ? 14'b0110000_1000000 : Z2);

        // start held from the DONE cycle: only the following idle cycle accepts it
        launch(2'b00, 0, 3'd1, 0, 3'd2, t);
        wait_done("done_hold_a", t, 8);
        bus.op = 2'b00; bus.a_neg = 0; bus.a_mag = 3'd4; bus.b_neg = 0; bus.b_mag = 3'd4;
        bus.start = 1'b1;
        step();
        t = cyc;
        step();
        bus.start = 1'b0;
        wait_done("done_hold_b", t, 8);
        chk("done_hold_b_mag", bus.res_mag, 8);
        chk("done_hold_b_seg", bus.seg_out, 14'b1000000_0000000);
        step();

        // start while busy is dropped
        launch(2'b00, 0, 3'd5, 1, 3'd2, t);
        step();
        step();
        bus.op = 2'b10; bus.a_mag = 3'd7; bus.b_mag = 3'd7; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("busy_ign", t, 8);
        chk("busy_ign_mag", bus.res_mag, 3);
        step();
        count_done(14, c);
        chk("busy_ign_extra_done", c, 0);

        // reset mid-operation
        launch(2'b00, 1, 3'd7, 1, 3'd7, t);
        repeat (4) step();
        chk("abort_cycle", cyc - t, 5);
        ar = 1'b1;
        step();
        ar = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_mag",  bus.res_mag, 0);
        chk("abort_neg",  bus.res_neg, 0);
        chk("abort_err",  bus.err, 0);
        chk("abort_seg",  bus.seg_out, Z2);
        step();
        count_done(12, c);
        chk("abort_no_done", c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
